// File: rtl/cp0_tlb_sequencer_if.sv
// TLB entry layout, op codes and the grouped WB / TLB / cp0 signals of the
// CP0 TLB sequencer. The slave modport is the sequencer, master is its environment.
package cp0_tlb_pkg;
    typedef enum logic [1:0] {
        OP_TLBR  = 2'b00,
        OP_TLBWI = 2'b01,
        OP_TLBWR = 2'b10,
        OP_TLBP  = 2'b11
    } tlb_op_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [23:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [23:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } TLBEntry_t;
endpackage

interface cp0_tlb_sequencer_if #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
);
    import cp0_tlb_pkg::*;

    logic             op_valid;
    logic [1:0]       op_code;
    logic             op_ready;
    logic [31:0]      entry_hi;
    logic [31:0]      entry_lo0;
    logic [31:0]      entry_lo1;
    logic [31:0]      index;
    logic [31:0]      random;
    logic             flush;
    logic             tlb_req_valid;
    logic             tlb_req_we;
    logic [IDX_W-1:0] tlb_req_idx;
    TLBEntry_t        tlb_wdata;
    logic             tlb_req_ready;
    logic             tlb_rvalid;
    TLBEntry_t        tlb_rdata;
    logic             probe_valid;
    logic [18:0]      probe_vpn2;
    logic [7:0]       probe_asid;
    logic             probe_done;
    logic             probe_hit;
    logic [IDX_W-1:0] probe_idx;
    logic             tlbr_req;
    TLBEntry_t        tlbr_res;
    logic             tlbp_req;
    logic [31:0]      tlbp_res;
    logic             op_done;
    logic             busy;

    modport slave (
        input  op_valid, op_code, entry_hi, entry_lo0, entry_lo1, index, random, flush,
        input  tlb_req_ready, tlb_rvalid, tlb_rdata, probe_done, probe_hit, probe_idx,
        output op_ready, tlb_req_valid, tlb_req_we, tlb_req_idx, tlb_wdata,
        output probe_valid, probe_vpn2, probe_asid,
        output tlbr_req, tlbr_res, tlbp_req, tlbp_res, op_done, busy
    );

    modport master (
        output op_valid, op_code, entry_hi, entry_lo0, entry_lo1, index, random, flush,
        output tlb_req_ready, tlb_rvalid, tlb_rdata, probe_done, probe_hit, probe_idx,
        input  op_ready, tlb_req_valid, tlb_req_we, tlb_req_idx, tlb_wdata,
        input  probe_valid, probe_vpn2, probe_asid,
        input  tlbr_req, tlbr_res, tlbp_req, tlbp_res, op_done, busy
    );
endinterface

// File: rtl/cp0_tlb_sequencer.sv
// Multi-cycle sequencer for TLBR/TLBWI/TLBWR/TLBP: latches CP0 operands at accept,
// drives the TLB maintenance or probe port, and returns one-cycle results to cp0.
module cp0_tlb_sequencer
    import cp0_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input logic                clk,
    input logic                rst,
    cp0_tlb_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_PROBE, S_RESP, S_DRAIN
    } state_e;

    state_e           r_state;
    state_e           w_next_state;
    tlb_op_e          r_op;
    tlb_op_e          w_op;
    logic [IDX_W-1:0] r_idx;
    TLBEntry_t        r_entry;
    TLBEntry_t        w_entry;
    TLBEntry_t        r_tlbr_res;
    logic [31:0]      r_tlbp_res;
    logic             w_accept;
    logic             w_unused;

    assign w_op     = tlb_op_e'(bus.op_code);
    assign w_accept = (r_state == S_IDLE) && bus.op_valid && !bus.flush;
    assign w_unused = ^{bus.entry_hi[12:8], bus.entry_lo0[31:30], bus.entry_lo1[31:30],
                        bus.index[31:IDX_W], bus.random[31:IDX_W]};

    // NOTE: every combinational output gets a default before any branch, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_entry      = '0;
        w_entry.vpn2 = bus.entry_hi[31:13];
        w_entry.asid = bus.entry_hi[7:0];
        w_entry.g    = bus.entry_lo0[0] & bus.entry_lo1[0];
        w_entry.pfn0 = bus.entry_lo0[29:6];
        w_entry.c0   = bus.entry_lo0[5:3];
        w_entry.d0   = bus.entry_lo0[2];
        w_entry.v0   = bus.entry_lo0[1];
        w_entry.pfn1 = bus.entry_lo1[29:6];
        w_entry.c1   = bus.entry_lo1[5:3];
        w_entry.d1   = bus.entry_lo1[2];
        w_entry.v1   = bus.entry_lo1[1];
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A read the TLB has already accepted must have its response drained, even on flush.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_TLBR: w_next_state = S_READ;
                        OP_TLBP: w_next_state = S_PROBE;
                        default: w_next_state = S_WRITE;
                    endcase
                end
            end
            S_WRITE:   if (bus.tlb_req_ready || bus.flush) w_next_state = S_IDLE;
            S_READ: begin
                if (bus.tlb_req_ready)  w_next_state = bus.flush ? S_DRAIN : S_WAIT_RD;
                else if (bus.flush)     w_next_state = S_IDLE;
            end
            S_WAIT_RD: begin
                if (bus.flush)          w_next_state = bus.tlb_rvalid ? S_IDLE : S_DRAIN;
                else if (bus.tlb_rvalid) w_next_state = S_RESP;
            end
            S_PROBE: begin
                if (bus.flush)          w_next_state = S_IDLE;
                else if (bus.probe_done) w_next_state = S_RESP;
            end
            S_RESP:    w_next_state = S_IDLE;
            S_DRAIN:   if (bus.tlb_rvalid) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= OP_TLBR;
            r_idx      <= '0;
            r_entry    <= '0;
            r_tlbr_res <= '0;
            r_tlbp_res <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_entry <= w_entry;
                r_idx   <= (w_op == OP_TLBWR) ? bus.random[IDX_W-1:0] : bus.index[IDX_W-1:0];
            end
            if (r_state == S_WAIT_RD && bus.tlb_rvalid && !bus.flush) begin
                r_tlbr_res <= bus.tlb_rdata;
            end
            if (r_state == S_PROBE && bus.probe_done && !bus.flush) begin
                r_tlbp_res <= bus.probe_hit ? {{(32-IDX_W){1'b0}}, bus.probe_idx} : 32'h8000_0000;
            end
        end
    end

    assign bus.op_ready      = (r_state == S_IDLE);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.tlb_req_valid = (r_state == S_WRITE) || (r_state == S_READ);
    assign bus.tlb_req_we    = (r_state == S_WRITE);
    assign bus.tlb_req_idx   = r_idx;
    assign bus.tlb_wdata     = r_entry;
    assign bus.probe_valid   = (r_state == S_PROBE);
    assign bus.probe_vpn2    = r_entry.vpn2;
    assign bus.probe_asid    = r_entry.asid;
    assign bus.tlbr_req      = (r_state == S_RESP) && (r_op == OP_TLBR) && !bus.flush;
    assign bus.tlbp_req      = (r_state == S_RESP) && (r_op == OP_TLBP) && !bus.flush;
    assign bus.tlbr_res      = r_tlbr_res;
    assign bus.tlbp_res      = r_tlbp_res;
    // A write handshaken in the same cycle as a flush is already committed.
    assign bus.op_done       = ((r_state == S_WRITE) && bus.tlb_req_ready) ||
                               ((r_state == S_RESP) && !bus.flush);
endmodule

// File: tb/tb_cp0_tlb_sequencer.sv
// Directed plus randomized bench for cp0_tlb_sequencer; the bench plays WB, the TLB
// (backed by an entry array) and the probe unit, and checks against its own model.
module tb_cp0_tlb_sequencer;
    import cp0_tlb_pkg::*;

    localparam int TLB_ENTRIES = 16;
    localparam int IDX_W       = $clog2(TLB_ENTRIES);
    localparam int EW          = $bits(TLBEntry_t);

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    int        checks = 0;
    int        errors = 0;
    TLBEntry_t tlb_mem [TLB_ENTRIES];

    always #5 clk = ~clk;

    cp0_tlb_sequencer_if #(.TLB_ENTRIES(TLB_ENTRIES)) bus ();

    cp0_tlb_sequencer #(.TLB_ENTRIES(TLB_ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic TLBEntry_t rand_entry();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[EW-1:0];
    endfunction

    // Reference packing: fields are pulled out of the CP0 words by shifting.
    function automatic TLBEntry_t pack_entry(input logic [31:0] hi, input logic [31:0] lo0,
                                             input logic [31:0] lo1);
        TLBEntry_t e;
        e.vpn2 = 19'(hi >> 13);
        e.asid = 8'(hi);
        e.g    = 1'(lo0 & lo1);
        e.pfn0 = 24'(lo0 >> 6);
        e.c0   = 3'(lo0 >> 3);
        e.d0   = 1'(lo0 >> 2);
        e.v0   = 1'(lo0 >> 1);
        e.pfn1 = 24'(lo1 >> 6);
        e.c1   = 3'(lo1 >> 3);
        e.d1   = 1'(lo1 >> 2);
        e.v1   = 1'(lo1 >> 1);
        return e;
    endfunction

    task automatic issue(input tlb_op_e op, input logic [31:0] hi, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [31:0] idx, input logic [31:0] rnd);
        bus.op_valid  = 1'b1;
        bus.op_code   = op;
        bus.entry_hi  = hi;
        bus.entry_lo0 = lo0;
        bus.entry_lo1 = lo1;
        bus.index     = idx;
        bus.random    = rnd;
        #1;
        check("accept_ready", bus.op_ready, 1'b1);
        check("accept_busy", bus.busy, 1'b0);
        tick();
        bus.op_valid  = 1'b0;
        bus.op_code   = 2'($urandom);
        bus.entry_hi  = $urandom;
        bus.entry_lo0 = $urandom;
        bus.entry_lo1 = $urandom;
        bus.index     = $urandom;
        bus.random    = $urandom;
    endtask

    task automatic run_write(input tlb_op_e op, input logic [31:0] hi, input logic [31:0] lo0,
                             input logic [31:0] lo1, input logic [31:0] idx,
                             input logic [31:0] rnd, input int ready_delay);
        TLBEntry_t        exp_e;
        logic [IDX_W-1:0] exp_idx;
        exp_e   = pack_entry(hi, lo0, lo1);
        exp_idx = IDX_W'(((op == OP_TLBWR) ? rnd : idx) % TLB_ENTRIES);
        issue(op, hi, lo0, lo1, idx, rnd);
        for (int c = 0; c <= ready_delay; c++) begin
            bus.tlb_req_ready = (c == ready_delay);
            #1;
            check("wr_req_valid", bus.tlb_req_valid, 1'b1);
            check("wr_req_we", bus.tlb_req_we, 1'b1);
            check("wr_req_idx", bus.tlb_req_idx, exp_idx);
            check("wr_wdata", bus.tlb_wdata, exp_e);
            check("wr_probe_valid", bus.probe_valid, 1'b0);
            check("wr_strobes", {bus.tlbr_req, bus.tlbp_req}, 2'b00);
            check("wr_op_done", bus.op_done, c == ready_delay);
            tick();
        end
        bus.tlb_req_ready = 1'b0;
        tlb_mem[exp_idx] = exp_e;
    endtask

    task automatic run_read(input logic [31:0] idx, input int ready_delay, input int rvalid_delay);
        TLBEntry_t        exp_e;
        TLBEntry_t        sel;
        logic [IDX_W-1:0] exp_idx;
        exp_idx = IDX_W'(idx % TLB_ENTRIES);
        exp_e   = tlb_mem[exp_idx];
        sel     = rand_entry();
        issue(OP_TLBR, $urandom, $urandom, $urandom, idx, $urandom);
        for (int c = 0; c <= ready_delay; c++) begin
            bus.tlb_req_ready = (c == ready_delay);
            #1;
            check("rd_req_valid", bus.tlb_req_valid, 1'b1);
            check("rd_req_we", bus.tlb_req_we, 1'b0);
            check("rd_req_idx", bus.tlb_req_idx, exp_idx);
            check("rd_probe_valid", bus.probe_valid, 1'b0);
            check("rd_op_done", bus.op_done, 1'b0);
            if (c == ready_delay) sel = tlb_mem[bus.tlb_req_idx];
            tick();
        end
        bus.tlb_req_ready = 1'b0;
        for (int c = 0; c <= rvalid_delay; c++) begin
            bus.tlb_rvalid = (c == rvalid_delay);
            bus.tlb_rdata  = (c == rvalid_delay) ? sel : rand_entry();
            #1;
            check("rd_wait_req_valid", bus.tlb_req_valid, 1'b0);
            check("rd_wait_busy", bus.busy, 1'b1);
            check("rd_wait_strobe", {bus.tlbr_req, bus.op_done}, 2'b00);
            tick();
        end
        bus.tlb_rvalid = 1'b0;
        bus.tlb_rdata  = rand_entry();
        #1;
        check("rd_tlbr_req", bus.tlbr_req, 1'b1);
        check("rd_tlbp_req", bus.tlbp_req, 1'b0);
        check("rd_op_done_resp", bus.op_done, 1'b1);
        check("rd_tlbr_res", bus.tlbr_res, exp_e);
        tick();
        check("rd_strobe_once", bus.tlbr_req, 1'b0);
    endtask

    task automatic run_probe(input logic [31:0] hi, input logic hit, input logic [IDX_W-1:0] pidx,
                             input int done_delay);
        logic [31:0] exp_res;
        exp_res = hit ? 32'(pidx) : 32'h8000_0000;
        issue(OP_TLBP, hi, $urandom, $urandom, $urandom, $urandom);
        for (int c = 0; c <= done_delay; c++) begin
            bus.probe_done = (c == done_delay);
            bus.probe_hit  = hit;
            bus.probe_idx  = pidx;
            #1;
            check("pr_valid", bus.probe_valid, 1'b1);
            check("pr_vpn2", bus.probe_vpn2, 19'(hi >> 13));
            check("pr_asid", bus.probe_asid, 8'(hi));
            check("pr_req_valid", bus.tlb_req_valid, 1'b0);
            check("pr_early", {bus.tlbp_req, bus.op_done}, 2'b00);
            tick();
        end
        bus.probe_done = 1'b0;
        bus.probe_hit  = 1'($urandom);
        bus.probe_idx  = IDX_W'($urandom);
        #1;
        check("pr_tlbp_req", bus.tlbp_req, 1'b1);
        check("pr_tlbr_req", bus.tlbr_req, 1'b0);
        check("pr_tlbp_res", bus.tlbp_res, exp_res);
        check("pr_op_done", bus.op_done, 1'b1);
        check("pr_resp_probe_valid", bus.probe_valid, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.flush = 1'b0;
        bus.entry_hi = '0; bus.entry_lo0 = '0; bus.entry_lo1 = '0; bus.index = '0; bus.random = '0;
        bus.tlb_req_ready = 1'b0; bus.tlb_rvalid = 1'b0; bus.tlb_rdata = '0;
        bus.probe_done = 1'b0; bus.probe_hit = 1'b0; bus.probe_idx = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) tlb_mem[i] = rand_entry();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_ready", bus.op_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_valids", {bus.tlb_req_valid, bus.probe_valid}, 2'b00);
        check("rst_strobes", {bus.tlbr_req, bus.tlbp_req, bus.op_done}, 3'b000);
        check("rst_tlbr_res", bus.tlbr_res, '0);
        check("rst_tlbp_res", bus.tlbp_res, 32'h0);
        rst = 1'b1;
        tick();

        // Directed vectors, including minimum-latency cases
        run_write(OP_TLBWI, 32'h1234_A0FF, 32'h0000_0047, 32'h0000_0087, 32'd5, $urandom, 2);
        run_write(OP_TLBWR, $urandom, $urandom, $urandom, $urandom, 32'h0000_001B, 0);
        run_probe($urandom, 1'b1, IDX_W'(3), 0);
        run_probe($urandom, 1'b0, IDX_W'($urandom), 2);
        run_read(32'd5, 3, 0);
        run_read(32'h0000_001B, 0, 0);

        // Flush in WAIT_RD, response two cycles later
        issue(OP_TLBR, $urandom, $urandom, $urandom, $urandom, $urandom);
        bus.tlb_req_ready = 1'b1;
        #1;
        check("fw_req_valid", bus.tlb_req_valid, 1'b1);
        tick();
        bus.tlb_req_ready = 1'b0;
        bus.flush = 1'b1;
        #1;
        check("fw_flush_strobes", {bus.tlbr_req, bus.op_done}, 2'b00);
        tick();
        bus.flush = 1'b0;
        #1;
        check("fw_drain_busy", bus.busy, 1'b1);
        check("fw_drain_ready", bus.op_ready, 1'b0);
        tick();
        bus.tlb_rvalid = 1'b1;
        bus.tlb_rdata  = rand_entry();
        #1;
        check("fw_rvalid_strobes", {bus.tlbr_req, bus.op_done}, 2'b00);
        tick();
        bus.tlb_rvalid = 1'b0;
        #1;
        check("fw_idle_ready", bus.op_ready, 1'b1);
        check("fw_idle_strobes", {bus.tlbr_req, bus.op_done}, 2'b00);
        tick();

        // Flush in WRITE before the handshake aborts it
        issue(OP_TLBWI, $urandom, $urandom, $urandom, $urandom, $urandom);
        bus.flush = 1'b1;
        #1;
        check("fwr_op_done", bus.op_done, 1'b0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("fwr_idle", {bus.op_ready, bus.tlb_req_valid}, 2'b10);
        tick();

        // Flush in IDLE blocks acceptance
        bus.op_valid = 1'b1;
        bus.op_code  = OP_TLBP;
        bus.flush    = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        check("fidle_not_accepted", {bus.busy, bus.probe_valid}, 2'b00);
        tick();

        // Reset asserted during PROBE
        issue(OP_TLBP, $urandom, $urandom, $urandom, $urandom, $urandom);
        #1;
        check("rp_probe_valid", bus.probe_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("rp_probe_valid_rst", bus.probe_valid, 1'b0);
        check("rp_op_ready", bus.op_ready, 1'b1);
        check("rp_tlbp_res", bus.tlbp_res, 32'h0);
        check("rp_tlbr_res", bus.tlbr_res, '0);
        tick();
        rst = 1'b1;
        bus.probe_done = 1'b1;
        bus.probe_hit  = 1'b1;
        bus.probe_idx  = IDX_W'(3);
        #1;
        check("rp_late_done", {bus.tlbp_req, bus.op_done}, 2'b00);
        tick();
        bus.probe_done = 1'b0;
        #1;
        check("rp_after", {bus.tlbp_req, bus.op_ready}, 2'b01);
        tick();

        // Randomized back-to-back traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: run_read($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
                1: run_write(OP_TLBWI, $urandom, $urandom, $urandom, $urandom, $urandom,
                             $urandom_range(0, 3));
                2: run_write(OP_TLBWR, $urandom, $urandom, $urandom, $urandom, $urandom,
                             $urandom_range(0, 3));
                default: run_probe($urandom, 1'($urandom), IDX_W'($urandom), $urandom_range(0, 3));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
